data_fetch_buf: RTL and testbench

//  Sits directly downstream of data_req.
//  - Tracks each data-BRAM read issued by data_req (rden) through a fixed BRAM read latency.
//  - Captures the returned words into a small first-word-fall-through (FWFT) FIFO.
//  - Presents the words to the PE array with a valid/ready handshake.
//  - Generates the stall that throttles data_req, so the FIFO can never overflow.

---
 rtl/data_fetch_buf.sv | 131 +++++++++++++
 tb/tb_data_fetch_buf.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : data_fetch_buf
//  Purpose  : Tracks data-BRAM reads through the read latency, buffers returned
//             words in an FWFT FIFO and throttles the requester via o_stall.
//  Revision : 1.0
// ============================================================================
module data_fetch_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rden,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_flush,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_stall,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [REG_WIDTH-1:0]  dbg_fetch_cnt,
    output logic                  dbg_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SUM_W = CNT_WIDTH + $clog2(RD_LATENCY + 1);

    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d, pipe_shift;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [REG_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  push, pop, full, accept, drop;
    logic [SUM_W-1:0]      inflight;

    generate
        if (RD_LATENCY == 1) begin : g_pipe_single
            assign pipe_shift = i_rden;
        end else begin : g_pipe_multi
            assign pipe_shift = {vld_pipe_q[RD_LATENCY-2:0], i_rden};
        end
    endgenerate

    always_comb begin
        push   = vld_pipe_q[RD_LATENCY-1];
        full   = (count_q == CNT_WIDTH'(FIFO_DEPTH));
        pop    = (count_q != '0) & i_ready;
        accept = push & (~full | pop);
        drop   = push & full & ~pop;

        vld_pipe_d  = pipe_shift;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fetch_cnt_d = fetch_cnt_q;
        ovf_d       = ovf_q;

        // Flush wins over everything, including a word returning this cycle.
        if (i_flush) begin
            vld_pipe_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (accept) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                fetch_cnt_d = fetch_cnt_q + REG_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (accept && !pop) begin
                count_d = count_q + CNT_WIDTH'(1);
            end else if (!accept && pop) begin
                count_d = count_q - CNT_WIDTH'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SUM_W'(vld_pipe_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fetch_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fetch_cnt_q <= fetch_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: o_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept && !i_flush) begin
            mem_q[wr_ptr_q] <= i_rdata;
        end
    end

    assign o_valid       = (count_q != '0);
    assign o_empty       = ~o_valid;
    assign o_full        = full;
    assign o_data        = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_stall       = (SUM_W'(count_q) + inflight) >= SUM_W'(FIFO_DEPTH);
    assign dbg_fetch_cnt = fetch_cnt_q;
    assign dbg_ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_data_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_fetch_buf
//  Purpose  : Directed self-checking bench for data_fetch_buf with a queue
//             scoreboard and a latency-2 BRAM model.
//  Revision : 1.0
// ============================================================================
module tb_data_fetch_buf;

    logic        clk;
    logic        rst;
    logic        i_rden;
    logic [31:0] i_rdata;
    logic        i_flush;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_stall;
    logic        o_empty;
    logic        o_full;
    logic [31:0] dbg_fetch_cnt;
    logic        dbg_ovf;

    logic [31:0] req_word;
    logic [31:0] bram_pipe [2];
    logic [31:0] sb [$];
    int          checks   = 0;
    int          failures = 0;

    data_fetch_buf dut (
        .clk           (clk),
        .rst           (rst),
        .i_rden        (i_rden),
        .i_rdata       (i_rdata),
        .i_flush       (i_flush),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_stall       (o_stall),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .dbg_fetch_cnt (dbg_fetch_cnt),
        .dbg_ovf       (dbg_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: the word requested with rden appears two cycles later.
    always @(posedge clk) begin
        bram_pipe[0] <= i_rden ? req_word : 32'hDEAD_BEEF;
        bram_pipe[1] <= bram_pipe[0];
    end
    assign i_rdata = bram_pipe[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rden, input logic [31:0] w, input logic rdy,
                        input logic fl, input bit exp_push);
        logic [31:0] exp_word;
        i_rden   = rden;
        req_word = w;
        i_ready  = rdy;
        i_flush  = fl;
        if (rden && exp_push) sb.push_back(w);
        if (o_valid && rdy && !fl) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", o_data, 32'hFFFF_FFFF);
            end else begin
                exp_word = sb.pop_front();
                chk("pop_data", o_data, exp_word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int issued;
        logic [31:0] head;

        rst = 1'b0; i_rden = 1'b0; i_flush = 1'b0; i_ready = 1'b0; req_word = '0;
        #1;
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_empty", {31'b0, o_empty}, 1);
        chk("rst_full",  {31'b0, o_full},  0);
        chk("rst_stall", {31'b0, o_stall}, 0);
        chk("rst_data",  o_data, 0);
        chk("rst_fetch", dbg_fetch_cnt, 0);
        chk("rst_ovf",   {31'b0, dbg_ovf}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic FWFT latency and ordering
        chk("t1_v_c0", {31'b0, o_valid}, 0); tick(1, 32'hA, 1, 0, 1);
        chk("t1_v_c1", {31'b0, o_valid}, 0); tick(1, 32'hB, 1, 0, 1);
        chk("t1_v_c2", {31'b0, o_valid}, 0); tick(1, 32'hC, 1, 0, 1);
        chk("t1_v_c3", {31'b0, o_valid}, 1); tick(0, 0, 1, 0, 0);
        chk("t1_v_c4", {31'b0, o_valid}, 1); tick(0, 0, 1, 0, 0);
        chk("t1_v_c5", {31'b0, o_valid}, 1); tick(0, 0, 1, 0, 0);
        chk("t1_v_c6", {31'b0, o_valid}, 0);
        chk("t1_fetch", dbg_fetch_cnt, 3);
        chk("t1_sb_empty", sb.size(), 0);

        // Stall throttling with a blocked consumer
        issued = 0;
        for (int k = 0; k < 20; k++) begin
            if (!o_stall) begin
                tick(1, 32'h200 + issued, 0, 0, 1);
                issued++;
            end else begin
                tick(0, 0, 0, 0, 0);
            end
        end
        chk("t2_issued", issued, 8);
        chk("t2_full",  {31'b0, o_full},  1);
        chk("t2_stall", {31'b0, o_stall}, 1);
        chk("t2_ovf",   {31'b0, dbg_ovf}, 0);
        chk("t2_fetch", dbg_fetch_cnt, 11);
        chk("t2_stall_hold", {31'b0, o_stall}, 1);
        tick(0, 0, 1, 0, 0);
        chk("t2_stall_release", {31'b0, o_stall}, 0);
        for (int k = 0; k < 7; k++) tick(0, 0, 1, 0, 0);
        chk("t2_empty", {31'b0, o_empty}, 1);
        chk("t2_sb_empty", sb.size(), 0);

        // Push on full with simultaneous pop
        for (int k = 0; k < 8; k++) tick(1, 32'h300 + k, 0, 0, 1);
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0);
        chk("t3_full_pre", {31'b0, o_full}, 1);
        tick(1, 32'h3FF, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("t3_full_post", {31'b0, o_full}, 1);
        chk("t3_ovf",   {31'b0, dbg_ovf}, 0);
        chk("t3_fetch", dbg_fetch_cnt, 20);
        for (int k = 0; k < 8; k++) tick(0, 0, 1, 0, 0);
        chk("t3_empty", {31'b0, o_empty}, 1);
        chk("t3_sb_empty", sb.size(), 0);

        // Flush with three buffered words and two reads in flight
        for (int k = 0; k < 3; k++) tick(1, 32'h400 + k, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("t4_valid_pre", {31'b0, o_valid}, 1);
        tick(1, 32'h4A, 0, 0, 1);
        tick(1, 32'h4B, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        sb.delete();
        chk("t4_valid_post", {31'b0, o_valid}, 0);
        chk("t4_empty_post", {31'b0, o_empty}, 1);
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 0, 0);
        chk("t4_valid_late", {31'b0, o_valid}, 0);
        chk("t4_stall_late", {31'b0, o_stall}, 0);
        chk("t4_fetch", dbg_fetch_cnt, 23);

        // Forced read on a full FIFO is dropped
        for (int k = 0; k < 8; k++) tick(1, 32'h600 + k, 0, 0, 1);
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0);
        chk("t6_full_pre", {31'b0, o_full}, 1);
        head = sb[0];
        tick(1, 32'h6EE, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0);
        chk("t6_ovf",   {31'b0, dbg_ovf}, 1);
        chk("t6_head",  o_data, head);
        chk("t6_full",  {31'b0, o_full}, 1);
        chk("t6_fetch", dbg_fetch_cnt, 31);

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        chk("t5_valid", {31'b0, o_valid}, 0);
        chk("t5_stall", {31'b0, o_stall}, 0);
        chk("t5_data",  o_data, 0);
        chk("t5_empty", {31'b0, o_empty}, 1);
        chk("t5_full",  {31'b0, o_full},  0);
        chk("t5_fetch", dbg_fetch_cnt, 0);
        chk("t5_ovf",   {31'b0, dbg_ovf}, 0);
        sb.delete();
        @(posedge clk); #1;
        chk("t5_valid_held", {31'b0, o_valid}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        tick(1, 32'h5A, 1, 0, 1);
        tick(1, 32'h5B, 1, 0, 1);
        for (int k = 0; k < 4; k++) tick(0, 0, 1, 0, 0);
        chk("t5_resume_sb", sb.size(), 0);
        chk("t5_resume_fetch", dbg_fetch_cnt, 2);
        chk("t5_resume_empty", {31'b0, o_empty}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
